reg_file_scoreboard: RTL and testbench
======================================

Name: reg_file_scoreboard

Overview:
- Processor register file: one synchronous write port, two combinational read ports, same-cycle write-to-read bypass.
- Holds a per-register pending-write scoreboard. The decode stage is the reader/issuer; the write-back stage is the writer.
- Flags read-after-write and write-after-write hazards with a stall output.
- Sits between decode and write-back, beside the pipeline registers.

Parameters:
- WIDTH, 8, data width of each register.
- ADDR, 4, address width; NREG = 2**ADDR registers; register 0 is hardwired to zero.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears registers, scoreboard and counter.
- ra1  input  ADDR  read address, port 1 (source operand A of the instruction in decode).
- ra2  input  ADDR  read address, port 2 (source operand B).
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2.
- we  input  1  write enable from write-back.
- wa  input  ADDR  write address.
- wd  input  WIDTH  write data.
- issue_valid  input  1  decode presents an instruction that reads ra1/ra2 and will write issue_dst.
- issue_dst  input  ADDR  destination register of the issuing instruction.
- stall  output  1  hazard: the issue is not accepted this cycle.
- pending_cnt  output  ADDR+1  registered count of registers with an outstanding write.

Behaviour:
- Reset (async, immediate): all registers = 0, all pending bits = 0, pending_cnt = 0. stall then follows its combinational equation, which evaluates to 0 because no bit is pending. Reset asserted mid-operation discards all in-flight pending state with no completion.
- Register 0:
  - always reads 0;
  - writes to it are ignored;
  - never becomes pending;
  - never causes a stall.
- Write (write port):
  - At posedge clk with we=1 and wa!=0: regs[wa] <= wd.
  - pending[wa] is cleared unless it is re-set in the same cycle (see issue).
  - A write to a non-pending register is legal and does not change pending_cnt.
- Read (combinational, zero latency):
  - rdN = 0 if raN==0;
  - otherwise rdN = wd if (we && wa==raN), bypassing the write of the current cycle;
  - otherwise rdN = regs[raN].
  - Both ports may read the same address.
- Clear condition: clrN = we && wa==raN && wa!=0.
- Hazard, combinational: stall = issue_valid && (rawA || rawB || waw).
  - rawA = ra1!=0 && pending[ra1] && !clr1.
  - rawB = ra2!=0 && pending[ra2] && !clr2.
  - waw = issue_dst!=0 && pending[issue_dst] && !(we && wa==issue_dst).
  - stall = 0 when issue_valid=0.
- Issue accept: at posedge with issue_valid=1, stall=0 and issue_dst!=0, pending[issue_dst] <= 1.
  - If a write clears the same address in the same cycle, the set wins, because this is a new producer.
  - An issue to register 0 is accepted with no scoreboard effect.
- pending_cnt update, registered:
  - +1 on an accepted issue with issue_dst!=0;
  - -1 on a write (wa!=0) to a currently pending register;
  - net 0 when both occur.
  - pending_cnt always equals the popcount of the pending bits; it cannot exceed NREG-1 or underflow.
- Timing: no outputs are registered except pending_cnt. Data written at edge k is visible through regs from cycle k+1, and through the bypass during cycle k.

Test Plan:
- Reset then read: assert reset; ra1=3, ra2=0 -> rd1=0, rd2=0, stall=0, pending_cnt=0.
- Write and bypass: we=1, wa=5, wd=8'hA5, ra1=5 in the same cycle -> rd1=8'hA5 combinationally. Next cycle with we=0 -> rd1=8'hA5 from storage. Write wa=0, wd=8'hFF -> reading r0 returns 0.
- RAW stall and release:
  - issue_valid=1, issue_dst=4 accepted -> pending_cnt=1.
  - Next: issue_valid=1, ra1=4 -> stall=1.
  - Then we=1, wa=4, wd=8'h3C in the same cycle -> stall=0, rd1=8'h3C.
  - After that edge pending_cnt=1, because the second issue's dst (issue_dst=6) was accepted while r4 cleared.
- WAW: r7 pending; issue_valid=1, issue_dst=7, no write -> stall=1, pending_cnt unchanged. Same stimulus with we=1, wa=7 -> stall=0, pending[7] stays 1, pending_cnt unchanged.
- Counter saturation: issue distinct dst 1..15 back-to-back -> pending_cnt=15. Write r1..r15 -> pending_cnt decrements to 0. A write to a non-pending register leaves the count unchanged.
- Reset mid-operation: r2 and r9 pending, pending_cnt=2; pulse reset asynchronously between edges -> pending_cnt=0 immediately, r2 and r9 read 0, ra1=2 issue -> stall=0.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// Register file (r0 = 0) with write bypass and a pending-write scoreboard raising RAW/WAW stall.
// Reads and stall are combinational, pending_cnt is registered; stall holds off issue, writes are never held off.
module reg_file_scoreboard #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADDR-1:0]  ra1,
    input  logic [ADDR-1:0]  ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             we,
    input  logic [ADDR-1:0]  wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             issue_valid,
    input  logic [ADDR-1:0]  issue_dst,
    output logic             stall,
    output logic [ADDR:0]    pending_cnt
);
    localparam int NREG = 1 << ADDR;

    logic [WIDTH-1:0] regs [NREG];
    logic [NREG-1:0]  pending;

    logic wr_en;
    logic clr1;
    logic clr2;
    logic clr_dst;
    logic raw_a;
    logic raw_b;
    logic waw;
    logic accept;
    logic cnt_inc;
    logic cnt_dec;

    always_comb begin
        wr_en   = we && (wa != '0);
        clr1    = wr_en && (wa == ra1);
        clr2    = wr_en && (wa == ra2);
        clr_dst = wr_en && (wa == issue_dst);

        rd1 = '0;
        rd2 = '0;
        if (ra1 != '0) rd1 = clr1 ? wd : regs[ra1];
        if (ra2 != '0) rd2 = clr2 ? wd : regs[ra2];

        // A write landing this cycle resolves the hazard it would otherwise flag.
        raw_a = (ra1 != '0) && pending[ra1] && !clr1;
        raw_b = (ra2 != '0) && pending[ra2] && !clr2;
        waw   = (issue_dst != '0) && pending[issue_dst] && !clr_dst;
        stall = issue_valid && (raw_a || raw_b || waw);

        accept  = issue_valid && !stall && (issue_dst != '0);
        cnt_inc = accept;
        cnt_dec = wr_en && pending[wa];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            if (wr_en)  pending[wa]        <= 1'b0;
            // Issued after the clear so a new producer to the same register keeps it pending.
            if (accept) pending[issue_dst] <= 1'b1;
            pending_cnt <= pending_cnt + (ADDR+1)'(cnt_inc) - (ADDR+1)'(cnt_dec);
        end
    end
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Randomized and directed bench for reg_file_scoreboard with a queue-based scoreboard and monitor.
module tb_reg_file_scoreboard;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] ra1 = '0, ra2 = '0, wa = '0, issue_dst = '0;
    logic [7:0] wd = '0;
    logic       we = 1'b0, issue_valid = 1'b0;
    logic [7:0] rd1, rd2;
    logic       stall;
    logic [4:0] pending_cnt;

    reg_file_scoreboard #(.WIDTH(8), .ADDR(4)) dut (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd), .issue_valid(issue_valid), .issue_dst(issue_dst),
        .stall(stall), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rd1;
        logic [7:0] rd2;
        logic       stall;
        logic [4:0] cnt;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;

    // Reference model: plain arrays of register contents and outstanding-write flags.
    int  mem  [16];
    bit  pend [16];

    function automatic int model_read(int a, bit w, int waddr, int wdata);
        if (a == 0) return 0;
        if (w && waddr == a) return wdata;
        return mem[a];
    endfunction

    function automatic bit busy(int a, bit w, int waddr);
        return (a != 0) && pend[a] && !(w && waddr == a);
    endfunction

    function automatic int outstanding();
        int n = 0;
        for (int i = 0; i < 16; i++) if (pend[i]) n++;
        return n;
    endfunction

    task automatic step(input bit rst_i, input bit we_i, input int wa_i, input int wd_i,
                        input int ra1_i, input int ra2_i, input bit iv_i, input int dst_i,
                        input string nm);
        exp_t e;
        bit   st;
        we = we_i; wa = 4'(wa_i); wd = 8'(wd_i);
        ra1 = 4'(ra1_i); ra2 = 4'(ra2_i);
        issue_valid = iv_i; issue_dst = 4'(dst_i);
        if (rst_i) begin
            reset = 1'b1;
            for (int i = 0; i < 16; i++) begin mem[i] = 0; pend[i] = 0; end
        end
        st = iv_i && (busy(ra1_i, we_i, wa_i) || busy(ra2_i, we_i, wa_i) || busy(dst_i, we_i, wa_i));
        e.rd1   = 8'(model_read(ra1_i, we_i, wa_i, wd_i));
        e.rd2   = 8'(model_read(ra2_i, we_i, wa_i, wd_i));
        e.stall = st;
        e.cnt   = 5'(outstanding());
        e.nm    = nm;
        exp_q.push_back(e);
        @(negedge clk);
        if (rst_i) begin
            #1 reset = 1'b0;
        end
        @(posedge clk);
        if (we_i && wa_i != 0) begin
            mem[wa_i]  = wd_i;
            pend[wa_i] = 0;
        end
        if (iv_i && !st && dst_i != 0) pend[dst_i] = 1;
        #1;
    endtask

    task automatic idle(input int a1, input int a2, input string nm);
        step(0, 0, 0, 0, a1, a2, 0, 0, nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (rd1 !== e.rd1) begin bad++; $display("FAIL %s rd1 got=%h want=%h", e.nm, rd1, e.rd1); end
            total++;
            if (rd2 !== e.rd2) begin bad++; $display("FAIL %s rd2 got=%h want=%h", e.nm, rd2, e.rd2); end
            total++;
            if (stall !== e.stall) begin bad++; $display("FAIL %s stall got=%b want=%b", e.nm, stall, e.stall); end
            total++;
            if (pending_cnt !== e.cnt) begin bad++; $display("FAIL %s pending_cnt got=%0d want=%0d", e.nm, pending_cnt, e.cnt); end
        end
    end

    initial begin
        int guard;
        // Reset, then write/bypass/r0 behaviour.
        step(1, 0, 0, 0, 3, 0, 0, 0, "reset_read");
        step(1, 1, 5, 'hA5, 5, 0, 0, 0, "bypass");
        idle(5, 5, "stored");
        step(0, 1, 0, 'hFF, 0, 5, 0, 0, "write_r0");
        idle(0, 0, "read_r0");

        // RAW stall and release.
        step(0, 0, 0, 0, 0, 0, 1, 4, "issue4");
        step(0, 0, 0, 0, 4, 0, 1, 6, "raw_stall");
        step(0, 1, 4, 'h3C, 4, 0, 1, 6, "raw_release");
        idle(4, 6, "raw_after");

        // WAW with and without a coincident write.
        step(0, 0, 0, 0, 0, 0, 1, 7, "issue7");
        step(0, 0, 0, 0, 0, 0, 1, 7, "waw_stall");
        step(0, 1, 7, 'h11, 7, 0, 1, 7, "waw_clear");
        idle(7, 0, "waw_after");
        step(0, 1, 6, 'h66, 6, 0, 0, 0, "drain6");
        step(0, 1, 7, 'h77, 7, 0, 0, 0, "drain7");
        idle(6, 7, "drained");

        // Fill every register's scoreboard bit, then drain.
        for (int d = 1; d < 16; d++) step(0, 0, 0, 0, 0, 0, 1, d, "fill");
        idle(1, 15, "full");
        step(0, 0, 0, 0, 3, 0, 1, 0, "issue_r0_stall");
        for (int d = 1; d < 16; d++) step(0, 1, d, d * 3, d, 0, 0, 0, "drain");
        idle(1, 15, "empty");
        step(0, 1, 3, 'h5A, 3, 0, 0, 0, "write_nonpending");
        step(0, 0, 0, 0, 0, 0, 1, 0, "issue_r0");

        // Asynchronous reset in the middle of operation.
        step(0, 0, 0, 0, 0, 0, 1, 2, "issue2");
        step(0, 0, 0, 0, 0, 0, 1, 9, "issue9");
        idle(2, 9, "two_pending");
        step(1, 0, 0, 0, 2, 9, 1, 0, "mid_reset");
        idle(2, 9, "post_reset");

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            step(0, ($urandom_range(0, 1) == 1), $urandom_range(0, 15), $urandom_range(0, 255),
                 $urandom_range(0, 15), $urandom_range(0, 15),
                 ($urandom_range(0, 9) < 6), $urandom_range(0, 15), "random");
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_queue left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
